core_result_drain: RTL and testbench

CORE_RESULT_DRAIN -- requirements
Module: core_result_drain

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/result_fifo.sv | 67 ++++++
 rtl/core_result_drain.sv | 144 ++++++++++++++
 tb/tb_core_result_drain.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the core result drain
//
// Contents: drain FSM state enum, record header/trailer byte values,
// bytes per serialized record, and a helper that picks one record byte.
package riscv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DRAIN,
      ST_TRAILER,
      ST_DONE
   } drain_state_e;

   localparam logic [7:0]  HDR_BYTE     = 8'hA5;
   localparam logic [7:0]  TRL_BYTE     = 8'h5A;
   localparam int unsigned RECORD_BYTES = 7;

   // Byte idx of a serialized record: header, addr MSB first, data MSB first.
   function automatic logic [7:0] record_byte(input logic [2:0]  idx,
                                              input logic [15:0] addr,
                                              input logic [31:0] data);
      logic [7:0] b;
      case (idx)
         3'd0:    b = HDR_BYTE;
         3'd1:    b = addr[15:8];
         3'd2:    b = addr[7:0];
         3'd3:    b = data[31:24];
         3'd4:    b = data[23:16];
         3'd5:    b = data[15:8];
         3'd6:    b = data[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous record FIFO with occupancy count
//
// Ports:
//   clk, reset_n      clock, async active-low reset (empties the FIFO)
//   push, wdata       write request and data; ignored while full
//   pop, rdata        read request and head-of-queue data (show-ahead)
//   full, empty       occupancy flags
//   count             occupancy, log2(DEPTH)+1 bits
module result_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 44
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   // A push into a full FIFO is simply discarded; the caller flags it.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/core_result_drain.sv
// rtl/core_result_drain.sv - captures core result writes and drains them as bytes
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   i_core_req / o_core_grant          result-write window request / grant
//   i_uram_en, i_uram_wr_en,
//   i_uram_addr, i_uram_wr_data        result port; writes captured while granted
//   o_uram_emptied                     idle (or done) with nothing left to send
//   i_core_locked                      core finished; triggers the trailer byte
//   o_byte_data, o_byte_valid,
//   i_byte_ready                       serial byte stream to the UART TX
//   o_overflow                         sticky: a record was dropped (FIFO full)
//   o_done                             sticky: trailer sent, block terminal
module core_result_drain #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_core_req,
   output logic              o_core_grant,
   input  logic              i_uram_en,
   input  logic              i_uram_wr_en,
   input  logic [ADDR_W-1:0] i_uram_addr,
   input  logic [DATA_W-1:0] i_uram_wr_data,
   output logic              o_uram_emptied,
   input  logic              i_core_locked,
   output logic [7:0]        o_byte_data,
   output logic              o_byte_valid,
   input  logic              i_byte_ready,
   output logic              o_overflow,
   output logic              o_done
);

   import riscv_pkg::*;

   localparam int WIDTH = ADDR_W + DATA_W;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [2:0] LAST_IDX = 3'(RECORD_BYTES - 1);

   drain_state_e     state_q, state_d;
   logic [2:0]       byte_idx_q, byte_idx_d;
   logic             overflow_q, overflow_d;
   logic             emptied_q, emptied_d;

   logic             push, pop, full, empty;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rdata;
   logic [15:0]      rec_addr;
   logic [31:0]      rec_data;
   logic             byte_valid;
   logic [7:0]       byte_data;

   result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   ({i_uram_addr, i_uram_wr_data}),
      .pop     (pop),
      .rdata   (rdata),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // Writes are captured for every granted cycle, including the one where
   // the request drops.
   assign push     = (state_q == ST_GRANT) && i_uram_en && i_uram_wr_en;
   assign rec_addr = 16'(rdata[WIDTH-1:DATA_W]);
   assign rec_data = 32'(rdata[DATA_W-1:0]);

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      overflow_d = overflow_q | (push & full);
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Request takes priority over the trailer.
            if (i_core_req && empty)         state_d = ST_GRANT;
            else if (i_core_locked && empty) state_d = ST_TRAILER;
         end
         ST_GRANT: begin
            if (!i_core_req) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (empty) begin
               state_d = ST_IDLE;
            end else begin
               byte_valid = 1'b1;
               byte_data  = record_byte(byte_idx_q, rec_addr, rec_data);
               if (i_byte_ready) begin
                  if (byte_idx_q == LAST_IDX) begin
                     byte_idx_d = 3'd0;
                     pop        = 1'b1;
                     if (count == CW'(1)) state_d = ST_IDLE;
                  end else begin
                     byte_idx_d = byte_idx_q + 3'd1;
                  end
               end
            end
         end
         ST_TRAILER: begin
            byte_valid = 1'b1;
            byte_data  = TRL_BYTE;
            if (i_byte_ready) state_d = ST_DONE;
         end
         ST_DONE: begin
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered view of "idle/done with an empty FIFO" after this edge.
      emptied_d = ((state_d == ST_IDLE) || (state_d == ST_DONE)) &&
                  (count == (pop ? CW'(1) : CW'(0)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= 3'd0;
         overflow_q <= 1'b0;
         emptied_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         overflow_q <= overflow_d;
         emptied_q  <= emptied_d;
      end
   end

   assign o_core_grant   = (state_q == ST_GRANT);
   assign o_done         = (state_q == ST_DONE);
   assign o_overflow     = overflow_q;
   assign o_uram_emptied = emptied_q;
   assign o_byte_valid   = byte_valid;
   assign o_byte_data    = byte_data;

endmodule

// File: tb/tb_core_result_drain.sv
// tb/tb_core_result_drain.sv - scoreboard bench for core_result_drain
module tb_core_result_drain;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              i_core_req, o_core_grant;
   logic              i_uram_en, i_uram_wr_en;
   logic [ADDR_W-1:0] i_uram_addr;
   logic [DATA_W-1:0] i_uram_wr_data;
   logic              o_uram_emptied, i_core_locked;
   logic [7:0]        o_byte_data;
   logic              o_byte_valid, i_byte_ready;
   logic              o_overflow, o_done;

   core_result_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_core_req     (i_core_req),
      .o_core_grant   (o_core_grant),
      .i_uram_en      (i_uram_en),
      .i_uram_wr_en   (i_uram_wr_en),
      .i_uram_addr    (i_uram_addr),
      .i_uram_wr_data (i_uram_wr_data),
      .o_uram_emptied (o_uram_emptied),
      .i_core_locked  (i_core_locked),
      .o_byte_data    (o_byte_data),
      .o_byte_valid   (o_byte_valid),
      .i_byte_ready   (i_byte_ready),
      .o_overflow     (o_overflow),
      .o_done         (o_done)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   int          rdy_mode = 0;
   int          byte_cnt = 0;
   int          model_cnt = 0;
   logic        model_ovf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a record is accepted only while fewer than DEPTH are held,
   // and becomes seven bytes: header, 16-bit address, 32-bit data, MSB first.
   task automatic model_write(input int unsigned addr, input int unsigned data);
      if (model_cnt < DEPTH) begin
         model_cnt++;
         exp_q.push_back(8'hA5);
         exp_q.push_back(8'((addr / 256) % 256));
         exp_q.push_back(8'(addr % 256));
         exp_q.push_back(8'(data / 16777216));
         exp_q.push_back(8'((data / 65536) % 256));
         exp_q.push_back(8'((data / 256) % 256));
         exp_q.push_back(8'(data % 256));
      end else begin
         model_ovf = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      i_core_req = 1'b0; i_core_locked = 1'b0;
      i_uram_en = 1'b0; i_uram_wr_en = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      model_ovf = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
   endtask

   // One write window; addresses/data come from the arrays, gaps are random.
   task automatic window(input int n, input int unsigned addrs[$], input int unsigned datas[$],
                         input bit gaps, input bit last_on_drop);
      i_core_req = 1'b1;
      step();
      chk("grant_rise", o_core_grant, 1'b1);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            i_uram_en = 1'b1; i_uram_wr_en = 1'b0;
            i_uram_addr = ADDR_W'($urandom); i_uram_wr_data = $urandom;
            step();
         end
         i_uram_en = 1'b1; i_uram_wr_en = 1'b1;
         i_uram_addr = ADDR_W'(addrs[i]); i_uram_wr_data = datas[i];
         model_write(addrs[i] % 4096, datas[i]);
         if (last_on_drop && i == n - 1) i_core_req = 1'b0;
         step();
      end
      i_uram_en = 1'b0; i_uram_wr_en = 1'b0;
      if (!last_on_drop) begin
         i_core_req = 1'b0;
         step();
      end
      chk("grant_fall", o_core_grant, 1'b0);
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while (!(exp_q.size() == 0 && o_uram_emptied === 1'b1) && t < 3000) begin
         step();
         t++;
      end
      chk({name, "_drained"}, (t < 3000) ? 32'd1 : 32'd0, 32'd1);
      chk({name, "_emptied"}, o_uram_emptied, 1'b1);
      model_cnt = 0;
   endtask

   task automatic rand_window(input int n, input bit last_on_drop);
      int unsigned a[$], d[$];
      for (int i = 0; i < n; i++) begin
         a.push_back($urandom_range(0, 4095));
         d.push_back($urandom);
      end
      window(n, a, d, 1'b1, last_on_drop);
   endtask

   initial begin
      int unsigned a3[$], d3[$];
      int base, t;
      reset_n = 1'b0;
      i_core_req = 1'b0; i_core_locked = 1'b0;
      i_uram_en = 1'b0; i_uram_wr_en = 1'b0;
      i_uram_addr = '0; i_uram_wr_data = '0; i_byte_ready = 1'b1;

      fork
         forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
               0:       i_byte_ready = 1'b1;
               1:       i_byte_ready = ~i_byte_ready;
               default: i_byte_ready = 1'($urandom_range(0, 1));
            endcase
         end
         begin
            logic       stall_prev = 1'b0;
            logic [7:0] held = 8'h00;
            forever begin
               @(negedge clk);
               if (!reset_n) begin
                  stall_prev = 1'b0;
               end else begin
                  if (stall_prev) begin
                     chk("valid_held", o_byte_valid, 1'b1);
                     chk("data_stable", o_byte_data, held);
                  end
                  if (o_byte_valid && i_byte_ready) begin
                     if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'h0, o_byte_data}, 32'hFFFF_FFFF);
                     end else begin
                        chk("byte", o_byte_data, exp_q.pop_front());
                     end
                     byte_cnt++;
                  end
                  stall_prev = o_byte_valid && !i_byte_ready;
                  held = o_byte_data;
               end
            end
         end
      join_none

      #1;
      step();
      chk("rst_grant", o_core_grant, 1'b0);
      chk("rst_valid", o_byte_valid, 1'b0);
      chk("rst_data", o_byte_data, 8'h00);
      chk("rst_overflow", o_overflow, 1'b0);
      chk("rst_done", o_done, 1'b0);
      chk("rst_emptied", o_uram_emptied, 1'b1);
      reset_n = 1'b1;
      step();

      // Three known records, ready held high, then toggling ready.
      a3 = '{32'h001, 32'h002, 32'h003};
      d3 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      rdy_mode = 0;
      window(3, a3, d3, 1'b0, 1'b0);
      wait_drain("basic");
      rdy_mode = 1;
      window(3, a3, d3, 1'b0, 1'b0);
      wait_drain("toggle");

      // Random windows, including ones sized past the FIFO depth.
      for (int k = 0; k < 6; k++) begin
         rdy_mode = k % 3;
         rand_window($urandom_range(1, 20), 1'($urandom_range(0, 1)));
         wait_drain("rand");
         chk("rand_overflow", o_overflow, model_ovf);
      end

      // Seventeen writes into a fresh DUT: one dropped, overflow sticks.
      do_reset();
      rdy_mode = 2;
      rand_window(17, 1'b0);
      wait_drain("ovf");
      chk("ovf_set", o_overflow, 1'b1);
      rand_window(2, 1'b1);
      wait_drain("ovf2");
      chk("ovf_sticky", o_overflow, 1'b1);

      // Reset while the fourth byte of a record is on the bus.
      do_reset();
      rdy_mode = 0;
      base = byte_cnt;
      rand_window(2, 1'b0);
      t = 0;
      while (byte_cnt < base + 3 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("mid_reached", (t < 200) ? 32'd1 : 32'd0, 32'd1);
      step();
      chk("mid_valid_before", o_byte_valid, 1'b1);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_valid", o_byte_valid, 1'b0);
      chk("mid_rst_data", o_byte_data, 8'h00);
      chk("mid_rst_grant", o_core_grant, 1'b0);
      chk("mid_rst_emptied", o_uram_emptied, 1'b1);
      chk("mid_rst_overflow", o_overflow, 1'b0);
      chk("mid_rst_done", o_done, 1'b0);
      step();
      reset_n = 1'b1;
      base = byte_cnt;
      repeat (30) step();
      chk("mid_no_bytes", byte_cnt - base, 0);
      chk("mid_emptied", o_uram_emptied, 1'b1);

      // Locked with nothing captured: only the trailer, then terminal.
      do_reset();
      rdy_mode = 2;
      exp_q.push_back(8'h5A);
      i_core_locked = 1'b1;
      wait_drain("trailer");
      chk("trailer_done", o_done, 1'b1);
      i_core_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("done_no_grant", o_core_grant, 1'b0);
      end
      chk("done_sticky", o_done, 1'b1);

      // Request and lock together: the window wins, trailer follows the drain.
      do_reset();
      rdy_mode = 1;
      i_core_locked = 1'b1;
      rand_window(2, 1'b0);
      chk("lock_not_done", o_done, 1'b0);
      exp_q.push_back(8'h5A);
      wait_drain("req_lock");
      chk("req_lock_done", o_done, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
